// File: rtl/qid_issue_ctrl.sv
// ---------------------------------------------------------------------------
// qid_issue_ctrl
//   Issue sequencer between the instruction buffer FIFO and the quantum
//   instruction decoder (QID). Instructions are popped into a one-entry hold
//   register and presented to the QID. Measurement instructions that have
//   been issued are counted until their feedback returns, and
//   feedback-dependent instructions are held back while any measurement is
//   still outstanding. Returned xorz values are registered and forwarded.
//   qifdone flags that the program has been fully issued and all feedback
//   has returned.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   instbuf_dout        head of the instruction FIFO (valid when not empty)
//   instbuf_empty       instruction FIFO empty
//   instbuf_rd          pop the instruction FIFO this cycle (combinational)
//   fetch_done          fetch unit has written the last instruction
//   qid_inst            held instruction presented to the QID
//   qid_instbuf_empty   low when qid_inst is valid for the QID (combinational)
//   a_taken             QID consumed qid_inst this cycle
//   measfb_valid        one measurement result returned this cycle
//   measfb_xorz_in      xorz of the returned result
//   measfb_xorz         registered xorz forwarded to the QID
//   qifdone             all instructions issued and all feedback returned
//   pend_cnt            outstanding measurement count
//   fb_err              sticky: feedback arrived with nothing outstanding
// ---------------------------------------------------------------------------
module qid_issue_ctrl #(
  parameter int INST_BW   = 64,
  parameter int OPCODE_BW = 4,
  parameter logic [OPCODE_BW-1:0] MEAS_OPC_A = 4'h6,
  parameter logic [OPCODE_BW-1:0] MEAS_OPC_B = 4'h7,
  parameter logic [OPCODE_BW-1:0] DEP_OPC    = 4'h8,
  parameter int PEND_BW   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INST_BW-1:0] instbuf_dout,
  input  logic               instbuf_empty,
  output logic               instbuf_rd,
  input  logic               fetch_done,
  output logic [INST_BW-1:0] qid_inst,
  output logic               qid_instbuf_empty,
  input  logic               a_taken,
  input  logic               measfb_valid,
  input  logic [1:0]         measfb_xorz_in,
  output logic [1:0]         measfb_xorz,
  output logic               qifdone,
  output logic [PEND_BW-1:0] pend_cnt,
  output logic               fb_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [PEND_BW-1:0] PEND_ZERO = {PEND_BW{1'b0}};
  localparam logic [PEND_BW-1:0] PEND_MAX  = {PEND_BW{1'b1}};
  localparam logic [PEND_BW-1:0] PEND_ONE  = {{(PEND_BW-1){1'b0}}, 1'b1};

  // Opcode of an instruction word.
  function automatic logic [OPCODE_BW-1:0] opc_f(input logic [INST_BW-1:0] inst);
    return inst[INST_BW-1 -: OPCODE_BW];
  endfunction

  function automatic logic is_meas_f(input logic [OPCODE_BW-1:0] opc);
    return (opc == MEAS_OPC_A) || (opc == MEAS_OPC_B);
  endfunction

  function automatic logic is_dep_f(input logic [OPCODE_BW-1:0] opc);
    return (opc == DEP_OPC);
  endfunction

  // A dependent instruction waits for all feedback; a measurement waits
  // while the counter is full so the counter can never wrap.
  function automatic logic blocked_f(input logic                 valid,
                                     input logic [OPCODE_BW-1:0] opc,
                                     input logic [PEND_BW-1:0]   pend);
    return valid & ((is_dep_f(opc) & (pend != PEND_ZERO)) |
                    (is_meas_f(opc) & (pend == PEND_MAX)));
  endfunction

  logic [INST_BW-1:0] hold_inst_r;
  logic               hold_valid_r;
  logic [PEND_BW-1:0] pend_cnt_r;
  logic [1:0]         xorz_r;
  logic               qifdone_r;
  logic               fb_err_r;
  logic [1:0]         state_r;

  logic [OPCODE_BW-1:0] opc_s;
  logic                 blocked_s;
  logic                 qid_empty_s;
  logic                 take_s;
  logic                 pop_s;
  logic                 inc_s;
  logic                 dec_s;
  logic [INST_BW-1:0]   hold_inst_nxt_s;
  logic                 hold_valid_nxt_s;
  logic [PEND_BW-1:0]   pend_nxt_s;
  logic                 fb_err_nxt_s;
  logic [1:0]           xorz_nxt_s;
  logic [1:0]           state_nxt_s;
  logic                 done_cond_s;

  // Issue handshake, counter update and next-state decode.
  always_comb begin
    opc_s       = opc_f(hold_inst_r);
    blocked_s   = blocked_f(hold_valid_r, opc_s, pend_cnt_r);
    qid_empty_s = ~hold_valid_r | blocked_s;
    take_s      = a_taken & ~qid_empty_s;
    // rst gates the pop so nothing is requested while reset is asserted.
    pop_s       = ~rst & ~instbuf_empty & (~hold_valid_r | take_s) &
                  (state_r != ST_DONE);
    inc_s       = take_s & is_meas_f(opc_s);
    dec_s       = measfb_valid & (pend_cnt_r != PEND_ZERO);

    if (inc_s && !dec_s) begin
      pend_nxt_s = pend_cnt_r + PEND_ONE;
    end else if (dec_s && !inc_s) begin
      pend_nxt_s = pend_cnt_r - PEND_ONE;
    end else begin
      pend_nxt_s = pend_cnt_r;
    end

    fb_err_nxt_s = fb_err_r | (measfb_valid & (pend_cnt_r == PEND_ZERO) & ~inc_s);

    if (measfb_valid) begin
      xorz_nxt_s = measfb_xorz_in;
    end else begin
      xorz_nxt_s = xorz_r;
    end

    if (pop_s) begin
      hold_inst_nxt_s = instbuf_dout;
    end else begin
      hold_inst_nxt_s = hold_inst_r;
    end
    hold_valid_nxt_s = pop_s | (hold_valid_r & ~take_s);

    done_cond_s = fetch_done & instbuf_empty & ~hold_valid_r &
                  (pend_cnt_r == PEND_ZERO);

    // IDLE/ISSUE/WAIT track what the hold register will contain next.
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_ISSUE, ST_WAIT: begin
        if ((state_r == ST_IDLE) && done_cond_s) begin
          state_nxt_s = ST_DONE;
        end else if (!hold_valid_nxt_s) begin
          state_nxt_s = ST_IDLE;
        end else if (blocked_f(1'b1, opc_f(hold_inst_nxt_s), pend_nxt_s)) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_DONE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_inst_r  <= {INST_BW{1'b0}};
      hold_valid_r <= 1'b0;
      pend_cnt_r   <= PEND_ZERO;
      xorz_r       <= 2'b00;
      qifdone_r    <= 1'b0;
      fb_err_r     <= 1'b0;
      state_r      <= ST_IDLE;
    end else begin
      hold_inst_r  <= hold_inst_nxt_s;
      hold_valid_r <= hold_valid_nxt_s;
      pend_cnt_r   <= pend_nxt_s;
      xorz_r       <= xorz_nxt_s;
      qifdone_r    <= (state_nxt_s == ST_DONE);
      fb_err_r     <= fb_err_nxt_s;
      state_r      <= state_nxt_s;
    end
  end

  assign instbuf_rd        = pop_s;
  assign qid_instbuf_empty = qid_empty_s;
  assign qid_inst          = hold_inst_r;
  assign measfb_xorz       = xorz_r;
  assign qifdone           = qifdone_r;
  assign pend_cnt          = pend_cnt_r;
  assign fb_err            = fb_err_r;

endmodule

// File: tb/tb_qid_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_qid_issue_ctrl
//   Directed bench for qid_issue_ctrl (PEND_BW=2, so the counter saturates
//   at 3). A small queue stands in for the instruction FIFO.
// ---------------------------------------------------------------------------
module tb_qid_issue_ctrl;

  localparam int INST_BW = 64;
  localparam int PEND_BW = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [INST_BW-1:0] instbuf_dout;
  logic               instbuf_empty;
  logic               instbuf_rd;
  logic               fetch_done;
  logic [INST_BW-1:0] qid_inst;
  logic               qid_instbuf_empty;
  logic               a_taken;
  logic               measfb_valid;
  logic [1:0]         measfb_xorz_in;
  logic [1:0]         measfb_xorz;
  logic               qifdone;
  logic [PEND_BW-1:0] pend_cnt;
  logic               fb_err;

  qid_issue_ctrl #(.INST_BW(INST_BW), .PEND_BW(PEND_BW)) dut (
    .clk(clk), .rst(rst),
    .instbuf_dout(instbuf_dout), .instbuf_empty(instbuf_empty),
    .instbuf_rd(instbuf_rd), .fetch_done(fetch_done),
    .qid_inst(qid_inst), .qid_instbuf_empty(qid_instbuf_empty),
    .a_taken(a_taken), .measfb_valid(measfb_valid),
    .measfb_xorz_in(measfb_xorz_in), .measfb_xorz(measfb_xorz),
    .qifdone(qifdone), .pend_cnt(pend_cnt), .fb_err(fb_err)
  );

  always #5 clk = ~clk;

  logic [63:0] fifo[$];
  int n_cmp = 0;
  int n_err = 0;

  // Instructions used below (top nibble is the opcode).
  localparam logic [63:0] S0 = 64'h1000_0000_0000_00A0;
  localparam logic [63:0] S1 = 64'h2000_0000_0000_00A1;
  localparam logic [63:0] S2 = 64'h3000_0000_0000_00A2;
  localparam logic [63:0] S3 = 64'h0000_0000_0000_00A3;
  localparam logic [63:0] S4 = 64'h5000_0000_0000_00A4;
  localparam logic [63:0] MA = 64'h6000_0000_0000_0011;
  localparam logic [63:0] MB = 64'h7000_0000_0000_0022;
  localparam logic [63:0] DP = 64'h8000_0000_0000_0033;
  localparam logic [63:0] NI = 64'h2000_0000_0000_0044;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fifo_sync();
    instbuf_empty = (fifo.size() == 0);
    instbuf_dout  = (fifo.size() == 0) ? 64'h0 : fifo[0];
  endtask

  // One clock: the pop request seen before the edge removes the FIFO head.
  task automatic tick();
    logic rd;
    rd = instbuf_rd;
    @(posedge clk);
    #1;
    if (rd && fifo.size() != 0) void'(fifo.pop_front());
    fifo_sync();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] stream [5];
    stream[0] = S0; stream[1] = S1; stream[2] = S2; stream[3] = S3; stream[4] = S4;

    rst = 1'b1; a_taken = 1'b0; measfb_valid = 1'b0; measfb_xorz_in = 2'b00;
    fetch_done = 1'b0;
    for (int i = 0; i < 5; i++) fifo.push_back(stream[i]);
    fifo_sync();
    #1;

    // ---- reset with FIFO non-empty ----
    repeat (3) tick();
    check("rst_rd",      64'(instbuf_rd),        64'h0);
    check("rst_qempty",  64'(qid_instbuf_empty), 64'h1);
    check("rst_pend",    64'(pend_cnt),          64'h0);
    check("rst_qifdone", 64'(qifdone),           64'h0);
    check("rst_fberr",   64'(fb_err),            64'h0);
    check("rst_xorz",    64'(measfb_xorz),       64'h0);
    check("rst_inst",    qid_inst,               64'h0);
    rst = 1'b0; a_taken = 1'b1; fetch_done = 1'b1;
    #1;
    check("rel_rd",      64'(instbuf_rd),        64'h1);
    check("rel_qempty",  64'(qid_instbuf_empty), 64'h1);

    // ---- streaming, one per cycle ----
    tick();
    for (int i = 0; i < 5; i++) begin
      check("strm_inst",   qid_inst,               stream[i]);
      check("strm_qempty", 64'(qid_instbuf_empty), 64'h0);
      check("strm_rd",     64'(instbuf_rd),        (i < 4) ? 64'h1 : 64'h0);
      tick();
    end
    check("strm_empty_after", 64'(qid_instbuf_empty), 64'h1);
    check("strm_qifdone_early", 64'(qifdone), 64'h0);
    tick();
    check("strm_qifdone", 64'(qifdone), 64'h1);
    fifo.push_back(S0);
    fifo_sync();
    #1;
    check("done_no_pop", 64'(instbuf_rd), 64'h0);

    // ---- dependency: MEAS, MEAS, DEP with fetch_done ----
    rst = 1'b1;
    #1;
    check("arst_qifdone", 64'(qifdone), 64'h0);
    fifo.delete();
    fifo.push_back(MA); fifo.push_back(MB); fifo.push_back(DP);
    fifo_sync();
    tick();
    rst = 1'b0;
    #1;
    tick();
    check("dep_inst_ma", qid_inst, MA);
    check("dep_pend0",   64'(pend_cnt), 64'h0);
    tick();
    check("dep_pend1",   64'(pend_cnt), 64'h1);
    check("dep_inst_mb", qid_inst, MB);
    tick();
    check("dep_pend2",   64'(pend_cnt), 64'h2);
    check("dep_blocked", 64'(qid_instbuf_empty), 64'h1);
    check("dep_inst_dp", qid_inst, DP);
    tick();
    check("dep_still_blocked", 64'(qid_instbuf_empty), 64'h1);
    check("dep_no_qifdone",    64'(qifdone), 64'h0);
    measfb_valid = 1'b1; measfb_xorz_in = 2'b01;
    #1;
    tick();
    check("dep_fb1_pend",   64'(pend_cnt), 64'h1);
    check("dep_fb1_xorz",   64'(measfb_xorz), 64'h1);
    check("dep_fb1_qempty", 64'(qid_instbuf_empty), 64'h1);
    measfb_xorz_in = 2'b10;
    #1;
    tick();
    measfb_valid = 1'b0;
    #1;
    check("dep_fb2_pend",   64'(pend_cnt), 64'h0);
    check("dep_fb2_xorz",   64'(measfb_xorz), 64'h2);
    check("dep_issue",      64'(qid_instbuf_empty), 64'h0);
    tick();
    check("dep_taken",      64'(qid_instbuf_empty), 64'h1);
    check("dep_xorz_hold",  64'(measfb_xorz), 64'h2);
    check("dep_qifdone_early", 64'(qifdone), 64'h0);
    tick();
    check("dep_qifdone",    64'(qifdone), 64'h1);

    // ---- saturation at 3 ----
    rst = 1'b1;
    #1;
    fetch_done = 1'b0;
    fifo.delete();
    fifo.push_back(MA); fifo.push_back(MB); fifo.push_back(MA); fifo.push_back(MB);
    fifo.push_back(NI);
    fifo_sync();
    tick();
    rst = 1'b0;
    #1;
    repeat (4) tick();
    check("sat_pend3",   64'(pend_cnt), 64'h3);
    check("sat_blocked", 64'(qid_instbuf_empty), 64'h1);
    check("sat_inst",    qid_inst, MB);
    check("sat_no_pop",  64'(instbuf_rd), 64'h0);
    tick();
    check("sat_nowrap",  64'(pend_cnt), 64'h3);
    measfb_valid = 1'b1; measfb_xorz_in = 2'b01;
    #1;
    check("sat_fb_blocked", 64'(qid_instbuf_empty), 64'h1);
    tick();
    check("sat_fb_pend2",   64'(pend_cnt), 64'h2);
    check("sat_unblocked",  64'(qid_instbuf_empty), 64'h0);
    tick();
    measfb_valid = 1'b0;
    #1;
    check("sat_incdec_pend", 64'(pend_cnt), 64'h2);
    check("sat_next_inst",   qid_inst, NI);
    tick();
    measfb_valid = 1'b1; measfb_xorz_in = 2'b00;
    #1;
    tick();
    tick();
    measfb_valid = 1'b0;
    #1;
    check("sat_drained", 64'(pend_cnt), 64'h0);
    check("sat_fberr0",  64'(fb_err), 64'h0);

    // ---- spurious feedback ----
    measfb_valid = 1'b1; measfb_xorz_in = 2'b11;
    #1;
    tick();
    measfb_valid = 1'b0;
    #1;
    check("spur_fberr", 64'(fb_err), 64'h1);
    check("spur_pend",  64'(pend_cnt), 64'h0);
    check("spur_xorz",  64'(measfb_xorz), 64'h3);
    tick();
    check("spur_sticky", 64'(fb_err), 64'h1);

    // ---- async reset while waiting ----
    rst = 1'b1;
    #1;
    check("rst_clears_fberr", 64'(fb_err), 64'h0);
    fifo.delete();
    fifo.push_back(MA); fifo.push_back(MB); fifo.push_back(DP);
    fifo_sync();
    tick();
    rst = 1'b0;
    #1;
    repeat (3) tick();
    check("wait_pend2",  64'(pend_cnt), 64'h2);
    check("wait_qempty", 64'(qid_instbuf_empty), 64'h1);
    fifo.push_back(NI);
    fifo_sync();
    #1;
    rst = 1'b1;
    #1;
    check("arst_pend",   64'(pend_cnt), 64'h0);
    check("arst_qempty", 64'(qid_instbuf_empty), 64'h1);
    check("arst_rd",     64'(instbuf_rd), 64'h0);
    check("arst_inst",   qid_inst, 64'h0);
    rst = 1'b0;
    tick();
    check("arst_dep_lost", qid_inst, NI);
    check("arst_pend_after", 64'(pend_cnt), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
